// File: rtl/text_console_pkg.sv
// text_console_pkg: character codes, FSM states and cursor-step opcodes shared by the text console
package text_console_pkg;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_TAB      = 8'h09;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;
  typedef enum logic [1:0] {ST_IDLE, ST_CLR_LINE, ST_CLR_ALL} state_t;
  typedef enum logic [1:0] {OP_ADV, OP_LF, OP_BS, OP_TAB} step_op_t;
endpackage

// File: rtl/tc_cursor_step.sv
// tc_cursor_step: combinational next cursor position for advance/LF/BS/TAB with modulo wrap
module tc_cursor_step
  import text_console_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int TAB_W = 4,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  input  step_op_t         i_op,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_new_row
);
  logic [ROW_W-1:0] w_row_inc;
  int               w_tab;
  logic             w_wrap;
  assign w_row_inc = (i_row == ROW_W'(ROWS - 1)) ? '0 : i_row + ROW_W'(1);
  assign w_tab     = ((int'(i_col) / TAB_W) + 1) * TAB_W;
  // a tab stop beyond the last column behaves like a line feed
  assign w_wrap    = (i_op == OP_LF) || (i_op == OP_ADV && i_col == COL_W'(COLS - 1)) ||
                     (i_op == OP_TAB && w_tab >= COLS);
  assign o_new_row = w_wrap;
  assign o_row = w_wrap ? w_row_inc :
                 (i_op == OP_BS && i_col == '0 && i_row != '0) ? i_row - ROW_W'(1) : i_row;
  assign o_col = w_wrap ? '0 :
                 (i_op == OP_ADV) ? i_col + COL_W'(1) :
                 (i_op == OP_TAB) ? COL_W'(w_tab) :
                 (i_col != '0) ? i_col - COL_W'(1) :
                 (i_row != '0) ? COL_W'(COLS - 1) : '0;
endmodule

// File: rtl/uart_text_cursor.sv
// uart_text_cursor: turns received UART bytes into character-RAM writes at a moving cursor
module uart_text_cursor
  import text_console_pkg::*;
#(
  parameter int COLS           = 32,
  parameter int ROWS           = 4,
  parameter int TAB_W          = 4,
  parameter bit CLEAR_ON_NL    = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  input  logic             i_ovf_clr,
  output logic             o_ovf,
  output logic             o_wr_en,
  output logic [ROW_W-1:0] o_wr_row,
  output logic [COL_W-1:0] o_wr_col,
  output logic [7:0]       o_wr_data,
  output logic [ROW_W-1:0] o_cur_row,
  output logic [COL_W-1:0] o_cur_col
);
  state_t           r_state, w_state;
  logic [ROW_W-1:0] r_row, w_row, r_sw_row, w_sw_row, r_wr_row, w_wr_row, w_step_row;
  logic [COL_W-1:0] r_col, w_col, r_sw_col, w_sw_col, r_wr_col, w_wr_col, w_step_col;
  logic [7:0]       r_wr_data, w_wr_data;
  logic             r_wr_en, w_wr_en, r_ovf, w_ovf, w_new_row;
  logic             w_printable, w_move, w_origin, w_last_col, w_last_row;
  step_op_t         w_op;
  assign w_printable = i_rx_data >= CH_PRINT_LO && i_rx_data <= CH_PRINT_HI;
  assign w_move      = w_printable || i_rx_data == CH_LF || i_rx_data == CH_BS || i_rx_data == CH_TAB;
  assign w_op        = w_printable ? OP_ADV : i_rx_data == CH_LF ? OP_LF : i_rx_data == CH_BS ? OP_BS : OP_TAB;
  assign w_origin    = r_row == '0 && r_col == '0;
  assign w_last_col  = r_sw_col == COL_W'(COLS - 1);
  assign w_last_row  = r_sw_row == ROW_W'(ROWS - 1);
  tc_cursor_step #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W)) u_step (
    .i_row     (r_row),
    .i_col     (r_col),
    .i_op      (w_op),
    .o_row     (w_step_row),
    .o_col     (w_step_col),
    .o_new_row (w_new_row)
  );
  // next-state decode: byte handling in IDLE, space sweeps in the clear states
  always_comb begin
    w_state   = r_state;
    w_row     = r_row;
    w_col     = r_col;
    w_sw_row  = r_sw_row;
    w_sw_col  = r_sw_col;
    w_wr_en   = 1'b0;
    w_wr_row  = r_wr_row;
    w_wr_col  = r_wr_col;
    w_wr_data = r_wr_data;
    w_ovf     = (i_rx_valid && r_state != ST_IDLE) ? 1'b1 : i_ovf_clr ? 1'b0 : r_ovf;
    case (r_state)
      ST_IDLE: if (i_rx_valid) begin
        w_wr_en = w_printable || (i_rx_data == CH_BS && !w_origin);
        if (w_wr_en) begin
          w_wr_row  = w_printable ? r_row : w_step_row;
          w_wr_col  = w_printable ? r_col : w_step_col;
          w_wr_data = w_printable ? i_rx_data : CH_SPACE;
        end
        if (w_move) begin
          w_row = w_step_row;
          w_col = w_step_col;
        end
        if (i_rx_data == CH_CR) w_col = '0;
        if (w_move && w_new_row && CLEAR_ON_NL) w_state = ST_CLR_LINE;
        if (i_rx_data == CH_FF) w_state = ST_CLR_ALL;
      end
      ST_CLR_LINE: begin
        w_wr_en   = 1'b1;
        w_wr_row  = r_row;
        w_wr_col  = r_sw_col;
        w_wr_data = CH_SPACE;
        w_sw_col  = w_last_col ? '0 : r_sw_col + COL_W'(1);
        if (w_last_col) w_state = ST_IDLE;
      end
      ST_CLR_ALL: begin
        w_wr_en   = 1'b1;
        w_wr_row  = r_sw_row;
        w_wr_col  = r_sw_col;
        w_wr_data = CH_SPACE;
        w_sw_col  = w_last_col ? '0 : r_sw_col + COL_W'(1);
        if (w_last_col) w_sw_row = w_last_row ? '0 : r_sw_row + ROW_W'(1);
        if (w_last_col && w_last_row) begin
          w_state = ST_IDLE;
          w_row   = '0;
          w_col   = '0;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end
  // state, cursor, sweep counters and the registered write port; reset aborts any sweep
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLR_ALL : ST_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_sw_row  <= '0;
      r_sw_col  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_data <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_row     <= w_row;
      r_col     <= w_col;
      r_sw_row  <= w_sw_row;
      r_sw_col  <= w_sw_col;
      r_wr_en   <= w_wr_en;
      r_wr_row  <= w_wr_row;
      r_wr_col  <= w_wr_col;
      r_wr_data <= w_wr_data;
      r_ovf     <= w_ovf;
    end
  end
  assign o_rx_ready = r_state == ST_IDLE;
  assign o_ovf      = r_ovf;
  assign o_wr_en    = r_wr_en;
  assign o_wr_row   = r_wr_row;
  assign o_wr_col   = r_wr_col;
  assign o_wr_data  = r_wr_data;
  assign o_cur_row  = r_row;
  assign o_cur_col  = r_col;
endmodule
